// File: rtl/key_sched_pkg.sv
// Shared constants and helpers for the DES-family key schedule:
// shift table, PC-2 selection table, width-generic rotations, FSM states.
package key_sched_pkg;

    // Entry r (r=1 in the LSBs) is the left shift applied for round r.
    localparam logic [31:0] DES_SHIFT_TAB = {
        2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1,
        2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1, 2'd1
    };

    localparam int MAX_W = 64;

    // PC-2: output bit i (MSB first) takes DES input bit PC2_TAB[i] (1-based, MSB = 1).
    localparam int PC2_TAB [48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
    };

    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_e;

    function automatic logic [MAX_W-1:0] rotl(input logic [MAX_W-1:0] x, input int s,
                                              input int w);
        logic [MAX_W-1:0] m;
        logic [MAX_W-1:0] xm;
        int sm;
        m  = (w >= MAX_W) ? '1 : ((64'd1 << w) - 64'd1);
        xm = x & m;
        sm = s % w;
        if (sm == 0) return xm;
        return ((xm << sm) | (xm >> (w - sm))) & m;
    endfunction

    function automatic logic [MAX_W-1:0] rotr(input logic [MAX_W-1:0] x, input int s,
                                              input int w);
        return rotl(x, w - (s % w), w);
    endfunction

endpackage

// File: rtl/key_pc2_perm.sv
// Combinational DES PC-2 permutation: 56-bit {C,D} to 48-bit round subkey.
module key_pc2_perm
    import key_sched_pkg::*;
(
    input  logic [55:0] cd,
    output logic [47:0] subkey
);

    for (genvar i = 0; i < 48; i++) begin : g_bit
        assign subkey[47-i] = cd[56-PC2_TAB[i]];
    end

endmodule

// File: rtl/key_rotate_seq.sv
// Iterated DES-family key-schedule rotator: one C0/D0 in, one rotated Ci/Di per round out,
// encrypt (left, 1..N) or decrypt (right, N..1) order. Optional KEY_PC2_EN adds PC-2 subkey.
module key_rotate_seq
    import key_sched_pkg::*;
#(
    parameter int HALF_W                       = 28,
    parameter int NUM_ROUNDS                   = 16,
    parameter logic [2*NUM_ROUNDS-1:0] SHIFT_TAB = (2*NUM_ROUNDS)'(DES_SHIFT_TAB),
    parameter int RND_W                        = 6
)(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              decrypt,
    input  logic [HALF_W-1:0] C0,
    input  logic [HALF_W-1:0] D0,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [HALF_W-1:0] Ci,
    output logic [HALF_W-1:0] Di,
    output logic [RND_W-1:0]  out_round,
`ifdef KEY_PC2_EN
    output logic [47:0]       subkey,
`endif
    output logic              out_last
);

    function automatic int tot_shift();
        int t;
        t = 0;
        for (int r = 0; r < NUM_ROUNDS; r++) t += int'(SHIFT_TAB[2*r +: 2]);
        return t;
    endfunction

    localparam int TOT_MOD  = tot_shift() % HALF_W;
    localparam int FIRST_SH = int'(SHIFT_TAB[1:0]);
    localparam logic [RND_W-1:0] LAST_RND = RND_W'(NUM_ROUNDS);
    localparam logic [RND_W-1:0] ONE_R    = RND_W'(1);
    localparam logic [RND_W:0]   ONE_X    = (RND_W+1)'(1);

    if (HALF_W < 4 || HALF_W > MAX_W) begin : g_bad_w
        $error("key_rotate_seq: HALF_W out of range");
    end
    if (NUM_ROUNDS < 1 || NUM_ROUNDS > 63 || (1 << RND_W) <= NUM_ROUNDS) begin : g_bad_n
        $error("key_rotate_seq: NUM_ROUNDS/RND_W invalid");
    end

    function automatic logic [HALF_W-1:0] rot_n(input logic [HALF_W-1:0] x, input int s,
                                                input logic left);
        return HALF_W'(left ? rotl(MAX_W'(x), s, HALF_W) : rotr(MAX_W'(x), s, HALF_W));
    endfunction

    state_e            state_q, state_d;
    logic [HALF_W-1:0] c_q, c_d, d_q, d_d;
    logic [RND_W-1:0]  round_q, round_d;
    logic              last_q, last_d, valid_q, valid_d, dec_q, dec_d;
    logic              accept, hs, do_flush;
    logic [RND_W:0]    idx;
    logic [1:0]        amt;
    logic [HALF_W-1:0] c_step, d_step;

    assign accept   = in_valid && in_ready;
    assign hs       = valid_q && out_ready;
    assign do_flush = flush && (state_q == RUN);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = RUN;
            RUN:     if (flush || (hs && last_q)) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        in_ready = (state_q == IDLE);
    end

    // Encrypt moves to round r+1 (table entry r+1); decrypt undoes round r (entry r).
    always_comb begin
        idx = dec_q ? ({1'b0, round_q} - ONE_X) : {1'b0, round_q};
        amt = '0;
        for (int r = 0; r < NUM_ROUNDS; r++) begin
            if (idx == (RND_W+1)'(r)) amt = SHIFT_TAB[2*r +: 2];
        end
    end

    always_comb begin
        c_step = c_q;
        d_step = d_q;
        case (amt)
            2'd1: begin c_step = rot_n(c_q, 1, !dec_q); d_step = rot_n(d_q, 1, !dec_q); end
            2'd2: begin c_step = rot_n(c_q, 2, !dec_q); d_step = rot_n(d_q, 2, !dec_q); end
            2'd3: begin c_step = rot_n(c_q, 3, !dec_q); d_step = rot_n(d_q, 3, !dec_q); end
            default: ;
        endcase
    end

    always_comb begin
        c_d     = c_q;
        d_d     = d_q;
        round_d = round_q;
        last_d  = last_q;
        valid_d = valid_q;
        dec_d   = dec_q;
        if (do_flush) begin
            valid_d = 1'b0;
            round_d = '0;
            last_d  = 1'b0;
        end else if (accept) begin
            valid_d = 1'b1;
            dec_d   = decrypt;
            last_d  = (NUM_ROUNDS == 1);
            if (decrypt) begin
                c_d     = rot_n(C0, TOT_MOD, 1'b1);
                d_d     = rot_n(D0, TOT_MOD, 1'b1);
                round_d = LAST_RND;
            end else begin
                c_d     = rot_n(C0, FIRST_SH, 1'b1);
                d_d     = rot_n(D0, FIRST_SH, 1'b1);
                round_d = ONE_R;
            end
        end else if (hs) begin
            if (last_q) begin
                valid_d = 1'b0;
                round_d = '0;
                last_d  = 1'b0;
            end else begin
                c_d = c_step;
                d_d = d_step;
                if (dec_q) begin
                    round_d = round_q - ONE_R;
                    last_d  = (round_q == RND_W'(2));
                end else begin
                    round_d = round_q + ONE_R;
                    last_d  = ((round_q + ONE_R) == LAST_RND);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            c_q     <= '0;
            d_q     <= '0;
            round_q <= '0;
            last_q  <= 1'b0;
            valid_q <= 1'b0;
            dec_q   <= 1'b0;
        end else begin
            c_q     <= c_d;
            d_q     <= d_d;
            round_q <= round_d;
            last_q  <= last_d;
            valid_q <= valid_d;
            dec_q   <= dec_d;
        end
    end

    assign Ci        = c_q;
    assign Di        = d_q;
    assign out_round = round_q;
    assign out_last  = last_q;
    assign out_valid = valid_q;

`ifdef KEY_PC2_EN
    if (HALF_W != 28) begin : g_bad_pc2
        $error("key_rotate_seq: KEY_PC2_EN requires HALF_W == 28");
    end

    logic [47:0] subkey_q, subkey_d;

    // Permuting the next-state halves keeps subkey aligned with Ci/Di.
    key_pc2_perm u_pc2 (
        .cd     ({c_d, d_d}),
        .subkey (subkey_d)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) subkey_q <= '0;
        else        subkey_q <= subkey_d;
    end

    assign subkey = subkey_q;
`endif

endmodule

// File: doc/key_rotate_seq.md
Name: key_rotate_seq

Overview:
Sequential DES-family key-schedule rotator. It accepts one C0/D0 half-key pair through a valid/ready handshake, then streams one rotated Ci/Di pair per round. Round shifts come from a parametrised per-round shift table, and output order is either encrypt (round 1..N, rotate left) or decrypt (round N..1, rotate right). It sits between the PC-1 stage and the round-function subkey input, replacing per-keyid combinational lookup with an iterated one-rotation-per-round datapath.

Parameters:
HALF_W, 28, width of each C/D half; must be >= 4
NUM_ROUNDS, 16, number of subkeys per key; 1..63
SHIFT_TAB, DES table {1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1}, packed 2*NUM_ROUNDS bits; entry r (r=1 in LSBs) is the left shift for round r; each entry 1..3
RND_W, 6, width of round index output; must hold NUM_ROUNDS

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
flush  in  1  synchronous abort; returns to IDLE
in_valid  in  1  C0/D0/decrypt valid
in_ready  out  1  block can accept a key (IDLE)
decrypt  in  1  0: encrypt order/left rotate; 1: decrypt order/right rotate
C0  in  HALF_W  C half after PC-1; MSB = DES bit 1
D0  in  HALF_W  D half after PC-1; MSB = DES bit 1
out_valid  out  1  Ci/Di/out_round valid
out_ready  in  1  consumer accepts current round
Ci  out  HALF_W  rotated C for out_round
Di  out  HALF_W  rotated D for out_round
out_round  out  RND_W  schedule round number of Ci/Di, 1..NUM_ROUNDS
out_last  out  1  high with the final round of the key

Behaviour:
- Reset (async, rst_n=0): state=IDLE, in_ready=1, out_valid=0, out_last=0, Ci=Di=0, out_round=0; mid-run reset discards the key.
- States: IDLE -> RUN on in_valid&&in_ready; RUN -> IDLE on out_valid&&out_ready&&out_last, or on flush; flush in IDLE has no effect.
- in_ready = (state==IDLE), combinational from state only; no accept in the same cycle as the last handshake. First in_ready rises the cycle after it.
- Latency: key accepted at edge T -> out_valid=1 from T+1 with the first round.
- Encrypt: first output = rotl(C0,S[1]), round 1; each handshake: rotl(current,S[r+1]), round r+1.
- Decrypt: first output = rotl(C0, TOT mod HALF_W), round NUM_ROUNDS, where TOT = sum of S[1..N]; each handshake: rotr(current,S[r]), round r-1. Decrypt output k equals encrypt output N+1-k bit-exactly.
- Stall: while out_valid&&!out_ready, Ci/Di/out_round/out_last hold stable.
- out_last = (encrypt && round==N) || (decrypt && round==1). It is also the first output when N=1.
- flush: out_valid=0 the next cycle, Ci/Di hold their last value, and out_round/out_last clear. flush wins over a simultaneous handshake.
- decrypt is sampled only at accept. Changes during RUN are ignored.
- Rotations are modulo HALF_W; shifts are constants selected by round index (mux of up to 3 rotations, no barrel shifter).

Optional Feature:
KEY_PC2_EN. When defined, the block adds output subkey[47:0] = PC-2({Ci,Di}), registered in the same cycle as Ci/Di. It is valid with out_valid and resets to 0, and it requires HALF_W==28 (elaboration error otherwise). When undefined, there is no subkey port and no PC-2 logic.

Decomposition:
- Package key_sched_pkg: DES_SHIFT_TAB constant, PC2 index table (48 entries), rotl/rotr functions parametrised by width, state enum {IDLE,RUN}.
- Sub-module key_pc2_perm: combinational 56->48 permutation, instantiated only under KEY_PC2_EN.

Test Plan:
- Key 0x133457799BBCDFF1 (C0=0xF0CCAAF, D0=0x556678F), encrypt, out_ready=1 -> round1 Ci=0xE19955F Di=0xAACCF1E; round16 Ci=0xF0CCAAF Di=0x556678F with out_last=1; in_ready=1 one cycle later.
- Same key, decrypt -> out_round 16,15,...,1; first Ci=0xF0CCAAF; final Ci=0xE19955F with out_last at round 1; all 16 match encrypt reversed.
- Encrypt with out_ready toggling 1,0,0,1 randomly -> Ci/Di/out_round stable during stalls; exactly 16 handshakes, none lost or duplicated.
- flush at round 5, with a new key on in_valid -> out_valid=0 next cycle; in_ready=1; new key accepted, its round 1 correct.
- rst_n pulsed low mid-run at round 9 -> all outputs zero asynchronously; in_ready=1 after release; no spurious out_valid.
- KEY_PC2_EN defined, key above -> round1 subkey=0x1B02EFFC7072; with HALF_W=8, N=4, SHIFT_TAB={3,1,2,1}: C0=0x81 -> encrypt 0x03,0x0C,0x18,0xC0.
